stack_unit: RTL and testbench



---
 rtl/stack_unit.sv | 167 ++++++++++++++++
 tb/tb_stack_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// stack_unit: hardware stack sequencer for PUSH/POP/CALL/RET.
// Each operation works on a descending stack in an external memory and
// returns the updated SP to register-file entry R3.
// Optional feature: define STACK_GUARD_EN to refuse a push/call at SP=0x00
// or a pop/ret at SP=0xFF, reporting the refusal on stk_err.
module stack_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] sp_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              sp_wr_en,
    output logic [DATA_W-1:0] sp_wr_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              stk_err
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;

    typedef enum logic [1:0] {IDLE, WRITE, RADDR, RDATA} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] opnd_q;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] pop_data_q;
    logic [DATA_W-1:0] pc_q;
    logic              is_wr_op;
    logic              accept;
    logic              guard_hit;
    logic              err_q;

    // SP moves with 8-bit wraparound in both directions
    function automatic logic [DATA_W-1:0] sp_inc(input logic [DATA_W-1:0] s);
        return s + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] sp_dec(input logic [DATA_W-1:0] s);
        return s - DATA_W'(1);
    endfunction

    // PUSH and CALL both write the stack; they share op[0]=0
    assign is_wr_op = ~op[0];

    // A request is taken only from a quiet IDLE; a pending refusal blocks it
    assign accept = (state_q == IDLE) && start && !err_q && !rst;

`ifdef STACK_GUARD_EN
    // Refuse operations that would run off either end of the stack
    always_comb begin
        guard_hit = is_wr_op ? (sp_in == '0) : (sp_in == '1);
    end

    // One-cycle refusal marker, reported in the following IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && guard_hit;
    end
`else
    assign guard_hit = 1'b0;
    assign err_q     = 1'b0;
`endif

    // State register, returns to IDLE immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operation context captured at accept; later sp_in changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= op;
            opnd_q <= (op == OP_PUSH) ? push_data : pc_in;
            sp_q   <= sp_in;
        end
    end

    // Popped values are held until the next result of the same kind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_data_q <= '0;
            pc_q       <= '0;
        end else if (state_q == RDATA) begin
            if (op_q == OP_POP) pop_data_q <= mem_rdata;
            else                pc_q       <= mem_rdata;
        end
    end

    // Next-state and output decode; every strobe defaults low
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        sp_wr_en   = 1'b0;
        sp_wr_data = '0;
        pop_valid  = 1'b0;
        pc_load    = 1'b0;
        stk_err    = 1'b0;
        pop_data   = pop_data_q;
        pc_out     = pc_q;
        case (state_q)
            IDLE: begin
                if (err_q) begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    stk_err = 1'b1;
                end else if (accept) begin
                    busy = 1'b1;
                    if (!guard_hit) state_d = is_wr_op ? WRITE : RADDR;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = sp_q;
                mem_wdata  = opnd_q;
                sp_wr_en   = 1'b1;
                sp_wr_data = sp_dec(sp_q);
                done       = 1'b1;
                state_d    = IDLE;
            end
            RADDR: begin
                busy       = 1'b1;
                mem_re     = 1'b1;
                mem_addr   = sp_inc(sp_q);
                sp_wr_en   = 1'b1;
                sp_wr_data = sp_inc(sp_q);
                state_d    = RDATA;
            end
            RDATA: begin
                busy = 1'b1;
                done = 1'b1;
                // Present the read data in the same cycle as its strobe
                if (op_q == OP_POP) begin
                    pop_valid = 1'b1;
                    pop_data  = mem_rdata;
                end else begin
                    pc_load = 1'b1;
                    pc_out  = mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed scoreboard bench for stack_unit.
// Stimulus pushes hand-computed expected events into a queue; a monitor
// pops and compares each event the DUT presents. Build with STACK_GUARD_EN
// defined to exercise the guarded configuration.
module tb_stack_unit;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    localparam logic [2:0] EV_WR   = 3'd0;  // val = {addr, wdata}
    localparam logic [2:0] EV_RD   = 3'd1;  // val = addr
    localparam logic [2:0] EV_SP   = 3'd2;  // val = new SP
    localparam logic [2:0] EV_POP  = 3'd3;  // val = pop_data
    localparam logic [2:0] EV_PCL  = 3'd4;  // val = pc_out
    localparam logic [2:0] EV_DONE = 3'd5;  // val = {busy, stk_err}

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [15:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] push_data, pc_in, sp_in, mem_rdata;
    logic       busy, done, mem_we, mem_re, sp_wr_en, pop_valid, pc_load, stk_err;
    logic [7:0] mem_addr, mem_wdata, sp_wr_data, pop_data, pc_out;

    logic [7:0] mem [256];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         k;

    stack_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .push_data(push_data), .pc_in(pc_in), .sp_in(sp_in),
        .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data),
        .pop_data(pop_data), .pop_valid(pop_valid), .pc_load(pc_load),
        .pc_out(pc_out), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stack memory: synchronous write, read data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic expect_ev(input logic [2:0] kind, input int c, input logic [15:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] kind, input logic [15:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%h, required none", kind, cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.cyc !== cyc || e.val !== val) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%h, required kind=%0d cyc=%0d val=%h",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we)    observe(EV_WR,   {mem_addr, mem_wdata});
            if (mem_re)    observe(EV_RD,   {8'h00, mem_addr});
            if (sp_wr_en)  observe(EV_SP,   {8'h00, sp_wr_data});
            if (pop_valid) observe(EV_POP,  {8'h00, pop_data});
            if (pc_load)   observe(EV_PCL,  {8'h00, pc_out});
            if (done)      observe(EV_DONE, {14'h0, busy, stk_err});
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   {7'h0, busy},     8'h00);
        check({tag, "_done"},   {7'h0, done},     8'h00);
        check({tag, "_strobes"}, {3'h0, mem_we, mem_re, sp_wr_en, pop_valid, pc_load}, 8'h00);
        check({tag, "_stk_err"}, {7'h0, stk_err}, 8'h00);
        check({tag, "_mem_addr"}, mem_addr,       8'h00);
        check({tag, "_sp_wr_data"}, sp_wr_data,   8'h00);
        check({tag, "_pop_data"}, pop_data,       8'h00);
        check({tag, "_pc_out"},   pc_out,         8'h00);
    endtask

    task automatic begin_op(input logic [1:0] o, input logic [7:0] d, input logic [7:0] pc,
                            input logic [7:0] sp, output int acc);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        push_data = d;
        pc_in = pc;
        sp_in = sp;
        acc = cyc;
    endtask

    // Drop start, disturb sp_in while busy, and return ready for the next accept
    task automatic finish_op(input int lat);
        @(posedge clk);
        #1;
        start = 1'b0;
        sp_in = 8'h5A;
        repeat (lat - 2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        op = OP_PUSH;
        push_data = 8'h00;
        pc_in = 8'h00;
        sp_in = 8'h00;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // PUSH 0xAA at SP=0xFF
        begin_op(OP_PUSH, 8'hAA, 8'h00, 8'hFF, k);
        expect_ev(EV_WR,   k + 1, 16'hFFAA);
        expect_ev(EV_SP,   k + 1, 16'h00FE);
        expect_ev(EV_DONE, k + 1, 16'h0002);
        finish_op(2);

        // POP at SP=0xFE reads back 0xAA from 0xFF
        begin_op(OP_POP, 8'h00, 8'h00, 8'hFE, k);
        expect_ev(EV_RD,   k + 1, 16'h00FF);
        expect_ev(EV_SP,   k + 1, 16'h00FF);
        expect_ev(EV_POP,  k + 2, 16'h00AA);
        expect_ev(EV_DONE, k + 2, 16'h0002);
        finish_op(3);
        @(negedge clk);
        check("pop_data_held", pop_data, 8'hAA);

        // CALL pushes 0x3C at SP=0x80, RET restores SP to 0x80
        begin_op(OP_CALL, 8'h00, 8'h3C, 8'h80, k);
        expect_ev(EV_WR,   k + 1, 16'h803C);
        expect_ev(EV_SP,   k + 1, 16'h007F);
        expect_ev(EV_DONE, k + 1, 16'h0002);
        finish_op(2);
        begin_op(OP_RET, 8'h00, 8'h00, 8'h7F, k);
        expect_ev(EV_RD,   k + 1, 16'h0080);
        expect_ev(EV_SP,   k + 1, 16'h0080);
        expect_ev(EV_PCL,  k + 2, 16'h003C);
        expect_ev(EV_DONE, k + 2, 16'h0002);
        finish_op(3);
        @(negedge clk);
        check("pc_out_held", pc_out, 8'h3C);
        check("pop_data_kept", pop_data, 8'hAA);

        // start held through a POP: exactly one operation, sp_in change ignored
        begin_op(OP_POP, 8'h00, 8'h00, 8'h7F, k);
        expect_ev(EV_RD,   k + 1, 16'h0080);
        expect_ev(EV_SP,   k + 1, 16'h0080);
        expect_ev(EV_POP,  k + 2, 16'h003C);
        expect_ev(EV_DONE, k + 2, 16'h0002);
        @(posedge clk);
        #1;
        sp_in = 8'h33;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset while in RADDR aborts with no strobes or done
        begin_op(OP_POP, 8'h00, 8'h00, 8'h10, k);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        begin_op(OP_PUSH, 8'h11, 8'h00, 8'h40, k);
        expect_ev(EV_WR,   k + 1, 16'h4011);
        expect_ev(EV_SP,   k + 1, 16'h003F);
        expect_ev(EV_DONE, k + 1, 16'h0002);
        finish_op(2);

        // Stack boundaries: PUSH at 0x00 then POP at 0xFF
        begin_op(OP_PUSH, 8'h55, 8'h00, 8'h00, k);
`ifdef STACK_GUARD_EN
        expect_ev(EV_DONE, k + 1, 16'h0003);
`else
        expect_ev(EV_WR,   k + 1, 16'h0055);
        expect_ev(EV_SP,   k + 1, 16'h00FF);
        expect_ev(EV_DONE, k + 1, 16'h0002);
`endif
        finish_op(2);

        begin_op(OP_POP, 8'h00, 8'h00, 8'hFF, k);
`ifdef STACK_GUARD_EN
        expect_ev(EV_DONE, k + 1, 16'h0003);
        finish_op(2);
`else
        expect_ev(EV_RD,   k + 1, 16'h0000);
        expect_ev(EV_SP,   k + 1, 16'h0000);
        expect_ev(EV_POP,  k + 2, 16'h0055);
        expect_ev(EV_DONE, k + 2, 16'h0002);
        finish_op(3);
`endif

        // Normal operation right after the boundary case
        begin_op(OP_PUSH, 8'h77, 8'h00, 8'h20, k);
        expect_ev(EV_WR,   k + 1, 16'h2077);
        expect_ev(EV_SP,   k + 1, 16'h001F);
        expect_ev(EV_DONE, k + 1, 16'h0002);
        finish_op(2);

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
